// File: rtl/machine_dispatcher.sv
// rtl/machine_dispatcher.sv - round-robin scheduler of machine descriptions onto a configure_machine worker bank
//
// Accepts a stream of machine descriptions, dispatches each one to the first
// idle worker at or after the dispatch pointer, and collects one finished
// result per cycle from the first ready and busy worker at or after the
// collect pointer. Collected press counts are summed. done is raised once the
// last machine's result has been collected, and it holds until done_ack.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (also resets workers)
//   in_valid/in_last  machine description offered / final machine of stream
//   in_ready          a machine can be accepted this cycle
//   worker_load       one-hot, combinational: latch description into worker
//   worker_start      one-hot registered start pulse, cycle after load
//   worker_ready      per-worker result-valid level
//   worker_presses    per-worker result, worker i at [i*W +: W]
//   worker_accepted   one-hot, combinational: result consumed this cycle
//   total_presses     running sum of collected results (wraps)
//   overflow          sticky: the sum wrapped at least once this stream
//   num_dispatched    machines dispatched this stream
//   num_completed     results collected this stream
//   done              all results of the stream collected
//   done_ack          consumer has read the totals; return to idle
module machine_dispatcher #(
  parameter int NUM_WORKERS       = 2,
  parameter int MAX_NUM_PRESSES_W = 4,
  parameter int SUM_W             = 16,
  parameter int CNT_W             = 10
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  input  logic                                     in_last,
  output logic                                     in_ready,
  output logic [NUM_WORKERS-1:0]                   worker_load,
  output logic [NUM_WORKERS-1:0]                   worker_start,
  input  logic [NUM_WORKERS-1:0]                   worker_ready,
  input  logic [NUM_WORKERS*MAX_NUM_PRESSES_W-1:0] worker_presses,
  output logic [NUM_WORKERS-1:0]                   worker_accepted,
  output logic [SUM_W-1:0]                         total_presses,
  output logic                                     overflow,
  output logic [CNT_W-1:0]                         num_dispatched,
  output logic [CNT_W-1:0]                         num_completed,
  output logic                                     done,
  input  logic                                     done_ack
);

  localparam int PTR_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_WORKERS - 1);
  localparam logic [PTR_W:0]   NW_EXT   = (PTR_W+1)'(NUM_WORKERS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_WORKERS-1:0]  busy_q, busy_d;
  logic [PTR_W-1:0]        dp_q, dp_d;
  logic [PTR_W-1:0]        cp_q, cp_d;
  logic [SUM_W-1:0]        total_q, total_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_W-1:0]        ndisp_q, ndisp_d;
  logic [CNT_W-1:0]        ncomp_q, ncomp_d;
  logic [NUM_WORKERS-1:0]  start_q, start_d;
  logic                    done_q, done_d;

  logic                    handshake;
  logic                    disp_found;
  logic [PTR_W-1:0]        disp_idx;
  logic                    coll_found;
  logic [PTR_W-1:0]        coll_idx;
  logic [NUM_WORKERS-1:0]  coll_cand;
  logic [PTR_W:0]          disp_probe;
  logic [PTR_W:0]          coll_probe;
  logic [MAX_NUM_PRESSES_W-1:0] sel_presses;
  logic [SUM_W:0]          sum_ext;

  // Pointer increment modulo NUM_WORKERS; collapses to constant 0 for one worker.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
  endfunction

  // First idle worker searching upward from dp with wrap-around.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    disp_probe = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      disp_probe = {1'b0, dp_q} + (PTR_W+1)'(k);
      if (disp_probe >= NW_EXT) disp_probe = disp_probe - NW_EXT;
      if (!disp_found && !busy_q[disp_probe[PTR_W-1:0]]) begin
        disp_found = 1'b1;
        disp_idx   = disp_probe[PTR_W-1:0];
      end
    end
  end

  // Only busy workers are candidates, so a result that lingers after its
  // accept (busy already cleared) is never collected twice.
  assign coll_cand = worker_ready & busy_q;

  always_comb begin
    coll_found = 1'b0;
    coll_idx   = '0;
    coll_probe = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      coll_probe = {1'b0, cp_q} + (PTR_W+1)'(k);
      if (coll_probe >= NW_EXT) coll_probe = coll_probe - NW_EXT;
      if (!coll_found && coll_cand[coll_probe[PTR_W-1:0]]) begin
        coll_found = 1'b1;
        coll_idx   = coll_probe[PTR_W-1:0];
      end
    end
  end

  assign in_ready        = ((state_q == S_IDLE) || (state_q == S_RUN)) && disp_found;
  assign handshake       = in_valid && in_ready;
  assign worker_load     = handshake  ? (NUM_WORKERS'(1) << disp_idx) : '0;
  assign worker_accepted = coll_found ? (NUM_WORKERS'(1) << coll_idx) : '0;

  assign sel_presses = worker_presses[coll_idx*MAX_NUM_PRESSES_W +: MAX_NUM_PRESSES_W];
  assign sum_ext     = {1'b0, total_q} + (SUM_W+1)'(sel_presses);

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    dp_d    = dp_q;
    cp_d    = cp_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    ndisp_d = ndisp_q;
    ncomp_d = ncomp_q;
    start_d = '0;

    // A new stream clears the previous totals before its first dispatch lands.
    if ((state_q == S_IDLE) && handshake) begin
      total_d = '0;
      ovf_d   = 1'b0;
      ndisp_d = '0;
      ncomp_d = '0;
    end

    if (handshake) begin
      busy_d  = busy_d | worker_load;
      dp_d    = wrap_inc(disp_idx);
      ndisp_d = ndisp_d + CNT_W'(1);
      start_d = worker_load;
    end

    // Dispatch and collect never target the same worker (!busy vs busy).
    if (coll_found) begin
      busy_d  = busy_d & ~worker_accepted;
      cp_d    = wrap_inc(coll_idx);
      total_d = sum_ext[SUM_W-1:0];
      if (sum_ext[SUM_W]) ovf_d = 1'b1;
      ncomp_d = ncomp_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE:  if (handshake) state_d = in_last ? S_DRAIN : S_RUN;
      S_RUN:   if (handshake && in_last) state_d = S_DRAIN;
      S_DRAIN: if ((busy_q == '0) && !coll_found) state_d = S_DONE;
      S_DONE:  if (done_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= '0;
      dp_q    <= '0;
      cp_q    <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      ndisp_q <= '0;
      ncomp_q <= '0;
      start_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      dp_q    <= dp_d;
      cp_q    <= cp_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      ndisp_q <= ndisp_d;
      ncomp_q <= ncomp_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign worker_start   = start_q;
  assign total_presses  = total_q;
  assign overflow       = ovf_q;
  assign num_dispatched = ndisp_q;
  assign num_completed  = ncomp_q;
  assign done           = done_q;

endmodule

// File: tb/tb_machine_dispatcher.sv
// tb/tb_machine_dispatcher.sv - directed self-checking bench for machine_dispatcher
module tb_machine_dispatcher;

  localparam int NW    = 2;
  localparam int PW    = 4;
  localparam int SW    = 4;
  localparam int CW    = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [NW-1:0]     worker_load;
  logic [NW-1:0]     worker_start;
  logic [NW-1:0]     worker_ready;
  logic [NW*PW-1:0]  worker_presses;
  logic [NW-1:0]     worker_accepted;
  logic [SW-1:0]     total_presses;
  logic              overflow;
  logic [CW-1:0]     num_dispatched;
  logic [CW-1:0]     num_completed;
  logic              done;
  logic              done_ack;

  int vectors = 0;
  int errs    = 0;

  machine_dispatcher #(
    .NUM_WORKERS(NW),
    .MAX_NUM_PRESSES_W(PW),
    .SUM_W(SW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .worker_load(worker_load),
    .worker_start(worker_start),
    .worker_ready(worker_ready),
    .worker_presses(worker_presses),
    .worker_accepted(worker_accepted),
    .total_presses(total_presses),
    .overflow(overflow),
    .num_dispatched(num_dispatched),
    .num_completed(num_completed),
    .done(done),
    .done_ack(done_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_last        = 1'b0;
    worker_ready   = '0;
    worker_presses = '0;
    done_ack       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_total", total_presses, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ndisp", num_dispatched, 0);
    chk("rst_ncomp", num_completed, 0);
    chk("rst_start", worker_start, 0);

    // in_last without in_valid is ignored
    in_last = 1'b1;
    settle();
    chk("last_only_load", worker_load, 0);
    tick();
    chk("last_only_ndisp", num_dispatched, 0);
    chk("last_only_ready", in_ready, 1);

    // ---- single machine, result 3 after ~20 cycles ----
    in_valid = 1'b1;
    in_last  = 1'b1;
    settle();
    chk("s1_load", worker_load, 2'b01);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    settle();
    chk("s1_start", worker_start, 2'b01);
    chk("s1_in_ready_drain", in_ready, 0);
    chk("s1_ndisp", num_dispatched, 1);
    tick();
    chk("s1_start_pulse_end", worker_start, 0);
    repeat (18) tick();
    chk("s1_not_done_yet", done, 0);
    worker_ready   = 2'b01;
    worker_presses = {4'd0, 4'd3};
    settle();
    chk("s1_accept", worker_accepted, 2'b01);
    tick();
    chk("s1_linger_no_accept", worker_accepted, 0);
    chk("s1_total", total_presses, 3);
    chk("s1_ncomp", num_completed, 1);
    chk("s1_done_low", done, 0);
    tick();
    worker_ready = '0;
    settle();
    chk("s1_done", done, 1);
    chk("s1_total_done", total_presses, 3);
    chk("s1_in_ready_done", in_ready, 0);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    settle();
    chk("s1_ack_done", done, 0);
    chk("s1_ack_idle", in_ready, 1);
    chk("s1_total_kept", total_presses, 3);

    // reset so pointers start at 0 again
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();

    // ---- 4 machines, results 2,1,4,0 ----
    in_valid = 1'b1;
    in_last  = 1'b0;
    settle();
    chk("s2_load0", worker_load, 2'b01);
    tick();
    chk("s2_start0", worker_start, 2'b01);
    chk("s2_load1", worker_load, 2'b10);
    tick();
    done_ack = 1'b1;  // ignored outside DONE
    settle();
    chk("s2_start1", worker_start, 2'b10);
    chk("s2_full_not_ready", in_ready, 0);
    chk("s2_full_no_load", worker_load, 0);
    tick();
    done_ack       = 1'b0;
    worker_ready   = 2'b01;
    worker_presses = {4'd0, 4'd2};
    settle();
    chk("s2_acc_w0", worker_accepted, 2'b01);
    chk("s2_acc_w0_not_ready", in_ready, 0);
    tick();
    // worker 0 result lingers while it is re-dispatched
    settle();
    chk("s2_redisp_load", worker_load, 2'b01);
    chk("s2_linger_no_acc", worker_accepted, 0);
    chk("s2_total_2", total_presses, 2);
    tick();
    worker_ready   = 2'b10;
    worker_presses = {4'd1, 4'd0};
    in_last        = 1'b1;
    settle();
    chk("s2_redisp_start", worker_start, 2'b01);
    chk("s2_full2_not_ready", in_ready, 0);
    chk("s2_acc_w1", worker_accepted, 2'b10);
    chk("s2_ndisp3", num_dispatched, 3);
    tick();
    settle();
    chk("s2_load_last", worker_load, 2'b10);
    chk("s2_linger1_no_acc", worker_accepted, 0);
    chk("s2_total_3", total_presses, 3);
    tick();
    in_valid       = 1'b0;
    in_last        = 1'b0;
    worker_ready   = 2'b11;
    worker_presses = {4'd0, 4'd4};
    settle();
    chk("s2_drain_not_ready", in_ready, 0);
    chk("s2_ndisp4", num_dispatched, 4);
    chk("s2_both_acc_first", worker_accepted, 2'b01);
    tick();
    chk("s2_both_acc_second", worker_accepted, 2'b10);
    chk("s2_total_7a", total_presses, 7);
    tick();
    worker_ready = '0;
    settle();
    chk("s2_pre_done", done, 0);
    chk("s2_ncomp4", num_completed, 4);
    tick();
    chk("s2_done", done, 1);
    chk("s2_total_7", total_presses, 7);
    chk("s2_final_ndisp", num_dispatched, 4);
    chk("s2_overflow0", overflow, 0);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    settle();
    chk("s2_ack", done, 0);

    // ---- overflow with SUM_W=4: 9 + 9 = 2 ----
    // cp ended at 0 above, so a simultaneous collect would take worker 0 first
    in_valid = 1'b1;
    in_last  = 1'b0;
    settle();
    chk("s3_load0", worker_load, 2'b01);
    tick();
    chk("s3_total_cleared", total_presses, 0);
    chk("s3_ndisp_restart", num_dispatched, 1);
    chk("s3_ncomp_cleared", num_completed, 0);
    in_last = 1'b1;
    settle();
    chk("s3_load1", worker_load, 2'b10);
    tick();
    in_valid       = 1'b0;
    in_last        = 1'b0;
    worker_ready   = 2'b11;
    worker_presses = {4'd9, 4'd9};
    settle();
    chk("s3_acc_first_w0", worker_accepted, 2'b01);
    tick();
    chk("s3_acc_second_w1", worker_accepted, 2'b10);
    chk("s3_total_9", total_presses, 9);
    chk("s3_ovf_not_yet", overflow, 0);
    tick();
    worker_ready = '0;
    settle();
    chk("s3_total_wrap", total_presses, 2);
    chk("s3_overflow", overflow, 1);
    tick();
    chk("s3_done", done, 1);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk("s3_ovf_kept_idle", overflow, 1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    settle();
    chk("s4_load", worker_load, 2'b01);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    settle();
    chk("s4_ovf_cleared", overflow, 0);
    chk("s4_total_cleared", total_presses, 0);
    chk("s4_drain_busy", in_ready, 0);

    // ---- reset while draining with one worker busy ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("s5_rst_ready", in_ready, 1);
    chk("s5_rst_done", done, 0);
    chk("s5_rst_total", total_presses, 0);
    chk("s5_rst_ndisp", num_dispatched, 0);
    chk("s5_rst_start", worker_start, 0);
    in_valid = 1'b1;
    in_last  = 1'b1;
    settle();
    chk("s5_load", worker_load, 2'b01);
    tick();
    in_valid       = 1'b0;
    in_last        = 1'b0;
    worker_ready   = 2'b01;
    worker_presses = {4'd0, 4'd5};
    settle();
    chk("s5_start", worker_start, 2'b01);
    chk("s5_acc", worker_accepted, 2'b01);
    tick();
    worker_ready = '0;
    tick();
    chk("s5_done", done, 1);
    chk("s5_total", total_presses, 5);
    chk("s5_ncomp", num_completed, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
